load_store_unit: RTL and testbench
==================================

# load_store_unit

Memory stage sitting directly downstream of the ALU. It takes the ALU result as an effective address, together with rs2 store data and load/store control. It runs a request/acknowledge transaction with data memory, handling byte lanes, alignment checks and load sign/zero extension. It hands a single-cycle writeback pulse to the register-file write stage, and passes non-memory results through.

## Interface
- data_width, 32, datapath width; only 32 is supported
- clk  input  1  rising-edge clock; the block's only clock
- rst  input  1  reset, synchronous, active-high
- valid_in  input  1  execute stage presents an instruction
- ready_in  output  1  block accepts this cycle; transfer occurs when valid_in && ready_in
- alu_result  input  data_width  effective address, or pass-through result
- data_rs2  input  data_width  store data
- mem_read  input  1  load instruction
- mem_write  input  1  store instruction
- funct3  input  3  size/sign: 0 B, 1 H, 2 W, 4 BU, 5 HU
- rd  input  5  destination register tag
- mem_req  output  1  memory request, held until mem_ack
- mem_we  output  1  1 = write
- mem_addr  output  data_width  word address, {alu_result[31:2],2'b00}
- mem_be  output  4  byte enables
- mem_wdata  output  data_width  lane-positioned store data
- mem_ack  input  1  memory completes the request this cycle
- mem_rdata  input  data_width  read word, valid when mem_ack
- wb_valid  output  1  one-cycle writeback pulse
- wb_data  output  data_width  writeback value
- wb_rd  output  5  writeback register tag
- wb_err  output  1  with wb_valid: misaligned or illegal access

## Operation
- States: IDLE, WAIT.
- ready_in = (state == IDLE) && !rst.
- Accepted op classes:
  - Pass-through (mem_read = mem_write = 0): stay IDLE. Next cycle wb_valid=1, wb_data=alu_result, wb_rd=rd, wb_err=0.
  - Error: stay IDLE, no memory request. Next cycle wb_valid=1, wb_err=1, wb_data=0, wb_rd=rd. Error cases:
    - mem_read and mem_write both 1
    - funct3 not in {0,1,2,4,5}
    - store with funct3 in {4,5}
    - H with alu_result[0]=1
    - W with alu_result[1:0]≠0
  - Valid memory op: register mem_addr, mem_we, mem_be, mem_wdata, funct3, offset and rd, then go to WAIT.
- WAIT:
  - mem_req=1; mem_* held stable.
  - On mem_ack: capture the load result, return to IDLE, pulse wb_valid next cycle.
  - Stores: wb_valid pulses with wb_data=0; the consumer ignores the store pulse for register write.
- Byte enables, with off = alu_result[1:0]:
  - B: 4'b0001<<off
  - H: 4'b0011<<off
  - W: 4'b1111
- mem_wdata:
  - B: rs2[7:0] replicated ×4
  - H: rs2[15:0] replicated ×2
  - W: rs2
- Load extract:
  - B/BU: byte at lane off
  - H/HU: halfword at lane off[1]
  - Sign-extend B/H, zero-extend BU/HU, W unchanged.
- mem_ack while IDLE is ignored.
- mem_rdata is sampled only in the mem_ack cycle.

## Timing
- Reset (sync, evaluated at the edge) forces:
  - state=IDLE
  - mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0
  - wb_valid=0, wb_data=0, wb_rd=0, wb_err=0
- ready_in reads 0 while rst is high.
- Pass-through and error latency: accept at edge T, wb_valid high in cycle T+1 for exactly one cycle.
- Memory op, accepted at edge T:
  - mem_req high from cycle T+1.
  - ready_in low from T+1 through the ack cycle A.
  - wb_valid high in cycle A+1.
  - ready_in high in A+1, so a new op may be accepted at A+1.
  - Minimum latency: A=T+1, giving wb in T+2.
- Zero-wait ack (mem_ack in the first request cycle) is legal.
- Any number of wait cycles is legal; mem_* outputs do not change while mem_req=1.
- Reset mid-WAIT: request dropped, mem_req=0 from the next cycle, no wb_valid. A late mem_ack is ignored.
- wb_valid is never high in two consecutive cycles for a single op. Back-to-back pass-throughs give a wb_valid pulse every cycle.

## Test plan
- Reset, then one pass-through with alu_result=0x0000_1234, rd=5 → next cycle wb_valid=1, wb_data=0x1234, wb_rd=5, wb_err=0, mem_req never high.
- Store SB: alu_result=0x103, rs2=0xAABB_CCDD → mem_req with mem_addr=0x100, mem_be=4'b1000, mem_wdata=0xDDDD_DDDD, mem_we=1. Outputs hold over a 3-cycle ack delay; ready_in=0 throughout.
- Loads, all with mem_rdata=0x80FF_7F80:
  - LB @0x2 → wb_data=0xFFFF_FFFF
  - LBU @0x0 → wb_data=0x0000_0080
  - LH @0x2 → wb_data=0xFFFF_80FF
  - LHU @0x0 → wb_data=0x0000_7F80
  - LW → wb_data=0x80FF_7F80
- Misaligned LW @0x6, then SH @0x1, then funct3=3 → each gives wb_err=1 one cycle after accept, wb_data=0, mem_req stays 0.
- Zero-wait ack followed by a new valid_in in the A+1 cycle → second op accepted immediately; wb pulses appear in consecutive wb windows with the correct rd tags.
- rst asserted in the 2nd WAIT cycle, then mem_ack one cycle later → mem_req=0 after the reset edge, no wb_valid, ready_in=1 after rst falls.

Source files
------------

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: request/acknowledge data-memory bus between the LSU (master) and memory (slave)
interface load_store_unit_if #(parameter int data_width = 32);
    logic                    mem_req;
    logic                    mem_we;
    logic [data_width-1:0]   mem_addr;
    logic [3:0]              mem_be;
    logic [data_width-1:0]   mem_wdata;
    logic                    mem_ack;
    logic [data_width-1:0]   mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: memory stage doing byte-lane placement, alignment checks and load extension,
// with a one-cycle writeback pulse for loads, stores, errors and pass-through results.
module load_store_unit #(parameter int data_width = 32) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_in,
    output logic                  ready_in,
    input  logic [data_width-1:0] alu_result,
    input  logic [data_width-1:0] data_rs2,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [2:0]            funct3,
    input  logic [4:0]            rd,
    load_store_unit_if.master     mem,
    output logic                  wb_valid,
    output logic [data_width-1:0] wb_data,
    output logic [4:0]            wb_rd,
    output logic                  wb_err
);
    typedef enum logic {st_idle, st_wait} state_t;

    state_t          state, state_next;
    logic [2:0]      f3_q;
    logic [1:0]      off_q;
    logic [4:0]      rd_q;
    logic            accept, is_mem, is_h, is_w, err;
    logic [3:0]      be;
    logic [31:0]     wdata, ld_data;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;

    assign ready_in   = (state == st_idle) && !rst;
    assign accept     = valid_in && ready_in;
    assign mem.mem_req = (state == st_wait);

    always_comb begin
        is_mem = mem_read || mem_write;
        is_h   = funct3[1:0] == 2'b01;
        is_w   = funct3 == 3'd2;
        err    = is_mem && ((mem_read && mem_write)
                 || !(funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})
                 || (mem_write && funct3[2])
                 || (is_h && alu_result[0])
                 || (is_w && alu_result[1:0] != 2'b00));
        be     = is_w ? 4'b1111 : is_h ? 4'b0011 << alu_result[1:0] : 4'b0001 << alu_result[1:0];
        wdata  = is_w ? data_rs2 : is_h ? {2{data_rs2[15:0]}} : {4{data_rs2[7:0]}};
        // sign bit suppressed for the unsigned variants (funct3[2] set)
        ld_byte = mem.mem_rdata[8*off_q +: 8];
        ld_half = off_q[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
        ld_data = f3_q == 3'd2 ? mem.mem_rdata
                : f3_q[0] ? {{16{~f3_q[2] & ld_half[15]}}, ld_half}
                : {{24{~f3_q[2] & ld_byte[7]}}, ld_byte};
    end

    always_comb begin
        state_next = state;
        if (state == st_idle)
            state_next = (accept && is_mem && !err) ? st_wait : st_idle;
        else
            state_next = mem.mem_ack ? st_idle : st_wait;
    end

    always_ff @(posedge clk)
        if (rst) state <= st_idle;
        else     state <= state_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem.mem_we    <= 1'b0;
            mem.mem_be    <= 4'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            f3_q          <= 3'd0;
            off_q         <= 2'd0;
            rd_q          <= 5'd0;
            wb_valid      <= 1'b0;
            wb_data       <= '0;
            wb_rd         <= 5'd0;
            wb_err        <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            if (accept && !is_mem) begin
                wb_valid <= 1'b1;
                wb_data  <= alu_result;
                wb_rd    <= rd;
                wb_err   <= 1'b0;
            end else if (accept && err) begin
                wb_valid <= 1'b1;
                wb_data  <= '0;
                wb_rd    <= rd;
                wb_err   <= 1'b1;
            end else if (accept) begin
                mem.mem_we    <= mem_write;
                mem.mem_be    <= be;
                mem.mem_addr  <= {alu_result[31:2], 2'b00};
                mem.mem_wdata <= wdata;
                f3_q          <= funct3;
                off_q         <= alu_result[1:0];
                rd_q          <= rd;
            end else if (state == st_wait && mem.mem_ack) begin
                wb_valid <= 1'b1;
                wb_data  <= mem.mem_we ? '0 : ld_data;
                wb_rd    <= rd_q;
                wb_err   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed vectors with hand-computed expectations for load_store_unit
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_in = 1'b0;
    logic        ready_in;
    logic [31:0] alu_result = '0;
    logic [31:0] data_rs2 = '0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [4:0]  rd = '0;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_err;
    int          vectors = 0;
    int          miscompares = 0;

    load_store_unit_if #(.data_width(32)) bus ();

    load_store_unit #(.data_width(32)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .ready_in(ready_in),
        .alu_result(alu_result), .data_rs2(data_rs2), .mem_read(mem_read),
        .mem_write(mem_write), .funct3(funct3), .rd(rd), .mem(bus.master),
        .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd), .wb_err(wb_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic r, input logic w, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] rs2, input logic [4:0] tag);
        valid_in = 1'b1; mem_read = r; mem_write = w; funct3 = f3;
        alu_result = addr; data_rs2 = rs2; rd = tag;
        step();
        valid_in = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    endtask

    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [4:0] r, input logic [3:0] be, input logic [31:0] exp);
        issue(1'b1, 1'b0, f3, addr, 32'h0, r);
        chk({tag, " req"}, bus.mem_req, 1);
        chk({tag, " we"}, bus.mem_we, 0);
        chk({tag, " addr"}, bus.mem_addr, {addr[31:2], 2'b00});
        chk({tag, " be"}, bus.mem_be, be);
        bus.mem_rdata = 32'h80FF_7F80; bus.mem_ack = 1'b1;
        step();
        bus.mem_ack = 1'b0; bus.mem_rdata = 32'hDEAD_BEEF;
        chk({tag, " wb_valid"}, wb_valid, 1);
        chk({tag, " wb_data"}, wb_data, exp);
        chk({tag, " wb_rd"}, wb_rd, r);
        chk({tag, " wb_err"}, wb_err, 0);
        step();
        chk({tag, " wb pulse end"}, wb_valid, 0);
    endtask

    task automatic do_err(input string tag, input logic r, input logic w, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [4:0] t);
        issue(r, w, f3, addr, 32'h1234_5678, t);
        chk({tag, " wb_valid"}, wb_valid, 1);
        chk({tag, " wb_err"}, wb_err, 1);
        chk({tag, " wb_data"}, wb_data, 0);
        chk({tag, " wb_rd"}, wb_rd, t);
        chk({tag, " mem_req"}, bus.mem_req, 0);
        chk({tag, " ready"}, ready_in, 1);
        step();
        chk({tag, " wb pulse end"}, wb_valid, 0);
    endtask

    initial begin
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        step(); step();
        chk("rst ready_in", ready_in, 0);
        chk("rst mem_req", bus.mem_req, 0);
        chk("rst mem_addr", bus.mem_addr, 0);
        chk("rst mem_be", bus.mem_be, 0);
        chk("rst mem_wdata", bus.mem_wdata, 0);
        chk("rst wb_valid", wb_valid, 0);
        chk("rst wb_data", wb_data, 0);
        chk("rst wb_rd", wb_rd, 0);
        rst = 1'b0;
        step();
        chk("post-rst ready_in", ready_in, 1);

        issue(1'b0, 1'b0, 3'd0, 32'h0000_1234, 32'h0, 5'd5);
        chk("pass wb_valid", wb_valid, 1);
        chk("pass wb_data", wb_data, 32'h1234);
        chk("pass wb_rd", wb_rd, 5);
        chk("pass wb_err", wb_err, 0);
        chk("pass mem_req", bus.mem_req, 0);
        step();
        chk("pass pulse end", wb_valid, 0);

        issue(1'b0, 1'b1, 3'd0, 32'h0000_0103, 32'hAABB_CCDD, 5'd7);
        for (int i = 0; i < 3; i++) begin
            chk("sb mem_req", bus.mem_req, 1);
            chk("sb mem_we", bus.mem_we, 1);
            chk("sb mem_addr", bus.mem_addr, 32'h100);
            chk("sb mem_be", bus.mem_be, 4'b1000);
            chk("sb mem_wdata", bus.mem_wdata, 32'hDDDD_DDDD);
            chk("sb ready_in", ready_in, 0);
            chk("sb wb_valid", wb_valid, 0);
            step();
        end
        bus.mem_ack = 1'b1;
        chk("sb ack ready_in", ready_in, 0);
        chk("sb ack mem_addr", bus.mem_addr, 32'h100);
        step();
        bus.mem_ack = 1'b0;
        chk("sb wb_valid", wb_valid, 1);
        chk("sb wb_data", wb_data, 0);
        chk("sb wb_rd", wb_rd, 7);
        chk("sb done mem_req", bus.mem_req, 0);
        chk("sb done ready_in", ready_in, 1);
        step();

        do_load("lb@2", 3'd0, 32'h2, 5'd1, 4'b0100, 32'hFFFF_FFFF);
        do_load("lbu@0", 3'd4, 32'h0, 5'd2, 4'b0001, 32'h0000_0080);
        do_load("lh@2", 3'd1, 32'h2, 5'd3, 4'b1100, 32'hFFFF_80FF);
        do_load("lhu@0", 3'd5, 32'h0, 5'd4, 4'b0011, 32'h0000_7F80);
        do_load("lw@8", 3'd2, 32'h8, 5'd6, 4'b1111, 32'h80FF_7F80);

        do_err("lw@6", 1'b1, 1'b0, 3'd2, 32'h6, 5'd12);
        do_err("sh@1", 1'b0, 1'b1, 3'd1, 32'h1, 5'd13);
        do_err("f3=3", 1'b1, 1'b0, 3'd3, 32'h0, 5'd14);
        do_err("rd+wr", 1'b1, 1'b1, 3'd2, 32'h0, 5'd15);

        issue(1'b1, 1'b0, 3'd2, 32'h10, 32'h0, 5'd9);
        bus.mem_rdata = 32'h1234_5678; bus.mem_ack = 1'b1;
        step();
        bus.mem_ack = 1'b0;
        chk("b2b wb1 valid", wb_valid, 1);
        chk("b2b wb1 data", wb_data, 32'h1234_5678);
        chk("b2b wb1 rd", wb_rd, 9);
        chk("b2b ready A+1", ready_in, 1);
        issue(1'b0, 1'b0, 3'd0, 32'h0000_CAFE, 32'h0, 5'd10);
        chk("b2b wb2 valid", wb_valid, 1);
        chk("b2b wb2 data", wb_data, 32'h0000_CAFE);
        chk("b2b wb2 rd", wb_rd, 10);
        step();

        issue(1'b1, 1'b0, 3'd2, 32'h20, 32'h0, 5'd11);
        chk("rstw req1", bus.mem_req, 1);
        step();
        chk("rstw req2", bus.mem_req, 1);
        rst = 1'b1;
        step();
        chk("rstw mem_req", bus.mem_req, 0);
        chk("rstw wb_valid", wb_valid, 0);
        chk("rstw ready in rst", ready_in, 0);
        rst = 1'b0; bus.mem_ack = 1'b1;
        #1;
        chk("rstw ready after rst", ready_in, 1);
        step();
        bus.mem_ack = 1'b0;
        chk("rstw late ack wb", wb_valid, 0);
        chk("rstw late ack req", bus.mem_req, 0);
        step();
        chk("rstw wb quiet", wb_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
